// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I core constants, ALU opcode encoding and the register-hit helper.
// Contents: XLEN/REG_AW datapath defaults, alu_op_e ({funct7[5],funct3}), rd_hit().
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    // A producer writing rd satisfies source rs; x0 never counts as a producer.
    function automatic logic rd_hit(input logic [REG_AW-1:0] rd, input logic we, input logic [REG_AW-1:0] rs);
        return we && rd != '0 && rd == rs;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bus between decode, the ID/EX register, the later stages and the ALU.
// slave  (ID/EX stage): decoded fields, flush/backend stall and forwarding sources in; EX fields, operands, stall_out out.
// master (environment): the mirror view.
interface id_ex_stage_if;
    import riscv_pkg::*;

    logic              id_valid_in;
    logic [XLEN-1:0]   id_pc_in;
    logic [XLEN-1:0]   id_rs1_data_in;
    logic [XLEN-1:0]   id_rs2_data_in;
    logic [REG_AW-1:0] id_rs1_addr_in;
    logic [REG_AW-1:0] id_rs2_addr_in;
    logic [REG_AW-1:0] id_rd_addr_in;
    logic [XLEN-1:0]   id_imm_in;
    logic [3:0]        id_alu_opcode_in;
    logic              id_alu_src_in;
    logic              id_op1_pc_in;
    logic              id_reg_write_in;
    logic              id_mem_read_in;
    logic              id_mem_write_in;
    logic              flush_in;
    logic              backend_stall_in;
    logic [REG_AW-1:0] ex_mem_rd_addr_in;
    logic              ex_mem_reg_write_in;
    logic [XLEN-1:0]   ex_mem_result_in;
    logic [REG_AW-1:0] mem_wb_rd_addr_in;
    logic              mem_wb_reg_write_in;
    logic [XLEN-1:0]   mem_wb_result_in;
    logic              ex_valid_out;
    logic [XLEN-1:0]   ex_pc_out;
    logic [XLEN-1:0]   op_1_out;
    logic [XLEN-1:0]   op_2_out;
    logic [3:0]        alu_opcode_out;
    logic [XLEN-1:0]   store_data_out;
    logic [REG_AW-1:0] ex_rd_addr_out;
    logic              ex_reg_write_out;
    logic              ex_mem_read_out;
    logic              ex_mem_write_out;
    logic              stall_out;

    modport slave (
        input  id_valid_in, id_pc_in, id_rs1_data_in, id_rs2_data_in, id_rs1_addr_in, id_rs2_addr_in,
               id_rd_addr_in, id_imm_in, id_alu_opcode_in, id_alu_src_in, id_op1_pc_in, id_reg_write_in,
               id_mem_read_in, id_mem_write_in, flush_in, backend_stall_in, ex_mem_rd_addr_in,
               ex_mem_reg_write_in, ex_mem_result_in, mem_wb_rd_addr_in, mem_wb_reg_write_in, mem_wb_result_in,
        output ex_valid_out, ex_pc_out, op_1_out, op_2_out, alu_opcode_out, store_data_out, ex_rd_addr_out,
               ex_reg_write_out, ex_mem_read_out, ex_mem_write_out, stall_out
    );

    modport master (
        output id_valid_in, id_pc_in, id_rs1_data_in, id_rs2_data_in, id_rs1_addr_in, id_rs2_addr_in,
               id_rd_addr_in, id_imm_in, id_alu_opcode_in, id_alu_src_in, id_op1_pc_in, id_reg_write_in,
               id_mem_read_in, id_mem_write_in, flush_in, backend_stall_in, ex_mem_rd_addr_in,
               ex_mem_reg_write_in, ex_mem_result_in, mem_wb_rd_addr_in, mem_wb_reg_write_in, mem_wb_result_in,
        input  ex_valid_out, ex_pc_out, op_1_out, op_2_out, alu_opcode_out, store_data_out, ex_rd_addr_out,
               ex_reg_write_out, ex_mem_read_out, ex_mem_write_out, stall_out
    );

endinterface

// File: rtl/ex_forward_unit.sv
// ex_forward_unit: selects one EX source operand from EX/MEM, MEM/WB or the registered RF data.
// Ports: rs_addr/rf_data (registered source), ex_mem_*/mem_wb_* (producer rd, write enable, value), data (operand).
module ex_forward_unit
    import riscv_pkg::*;
(
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rf_data,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_we,
    input  logic [XLEN-1:0]   ex_mem_result,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_we,
    input  logic [XLEN-1:0]   mem_wb_result,
    output logic [XLEN-1:0]   data
);

    // EX/MEM holds the younger result, so it is checked first.
    always_comb data = rd_hit(ex_mem_rd, ex_mem_we, rs_addr) ? ex_mem_result :
                       rd_hit(mem_wb_rd, mem_wb_we, rs_addr) ? mem_wb_result : rf_data;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I ID/EX pipeline register with operand forwarding, load-use bubble and flush.
// Ports: clk_in, reset_in (sync, active-high), bus (id_ex_stage_if.slave: decode fields in, ALU operands and
// gated EX controls out, combinational stall_out back to decode).
// ID_EX_FORWARDING_EN: defined enables EX/MEM and MEM/WB forwarding; undefined uses raw RF data with a full
// RAW interlock against EX and EX/MEM.
module id_ex_stage
    import riscv_pkg::*;
(
    input logic          clk_in,
    input logic          reset_in,
    id_ex_stage_if.slave bus
);

`ifdef ID_EX_FORWARDING_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic              valid_q, alu_src_q, op1_pc_q, reg_write_q, mem_read_q, mem_write_q;
    logic [XLEN-1:0]   pc_q, rs1_q, rs2_q, imm_q;
    logic [REG_AW-1:0] rs1_addr_q, rs2_addr_q, rd_q;
    logic [3:0]        opcode_q;
    logic [XLEN-1:0]   fwd_rs1, fwd_rs2;
    logic              ex_reg_write, ex_mem_read, load_use, interlock, stall;

    // Fields load even on flush/bubble; only valid is cleared, and every control output is gated by it.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            opcode_q    <= '0;
            alu_src_q   <= 1'b0;
            op1_pc_q    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (!bus.backend_stall_in) begin
            valid_q     <= bus.id_valid_in & ~bus.flush_in & ~stall;
            pc_q        <= bus.id_pc_in;
            rs1_q       <= bus.id_rs1_data_in;
            rs2_q       <= bus.id_rs2_data_in;
            rs1_addr_q  <= bus.id_rs1_addr_in;
            rs2_addr_q  <= bus.id_rs2_addr_in;
            rd_q        <= bus.id_rd_addr_in;
            imm_q       <= bus.id_imm_in;
            opcode_q    <= bus.id_alu_opcode_in;
            alu_src_q   <= bus.id_alu_src_in;
            op1_pc_q    <= bus.id_op1_pc_in;
            reg_write_q <= bus.id_reg_write_in;
            mem_read_q  <= bus.id_mem_read_in;
            mem_write_q <= bus.id_mem_write_in;
        end
    end

    // With forwarding disabled the write enables are tied off, so both units pass RF data through.
    ex_forward_unit u_fwd_rs1 (
        .rs_addr(rs1_addr_q), .rf_data(rs1_q),
        .ex_mem_rd(bus.ex_mem_rd_addr_in), .ex_mem_we(bus.ex_mem_reg_write_in & FWD),
        .ex_mem_result(bus.ex_mem_result_in),
        .mem_wb_rd(bus.mem_wb_rd_addr_in), .mem_wb_we(bus.mem_wb_reg_write_in & FWD),
        .mem_wb_result(bus.mem_wb_result_in), .data(fwd_rs1)
    );

    ex_forward_unit u_fwd_rs2 (
        .rs_addr(rs2_addr_q), .rf_data(rs2_q),
        .ex_mem_rd(bus.ex_mem_rd_addr_in), .ex_mem_we(bus.ex_mem_reg_write_in & FWD),
        .ex_mem_result(bus.ex_mem_result_in),
        .mem_wb_rd(bus.mem_wb_rd_addr_in), .mem_wb_we(bus.mem_wb_reg_write_in & FWD),
        .mem_wb_result(bus.mem_wb_result_in), .data(fwd_rs2)
    );

    always_comb begin
        ex_reg_write = valid_q & reg_write_q;
        ex_mem_read  = valid_q & mem_read_q;
        load_use     = rd_hit(rd_q, ex_mem_read, bus.id_rs1_addr_in) | rd_hit(rd_q, ex_mem_read, bus.id_rs2_addr_in);
        interlock    = ~FWD & (rd_hit(rd_q, ex_reg_write, bus.id_rs1_addr_in) |
                               rd_hit(rd_q, ex_reg_write, bus.id_rs2_addr_in) |
                               rd_hit(bus.ex_mem_rd_addr_in, bus.ex_mem_reg_write_in, bus.id_rs1_addr_in) |
                               rd_hit(bus.ex_mem_rd_addr_in, bus.ex_mem_reg_write_in, bus.id_rs2_addr_in));
        stall        = ~reset_in & bus.id_valid_in & (load_use | interlock);
    end

    assign bus.stall_out        = stall;
    assign bus.ex_valid_out     = valid_q;
    assign bus.ex_pc_out        = pc_q;
    assign bus.op_1_out         = op1_pc_q ? pc_q : fwd_rs1;
    assign bus.op_2_out         = alu_src_q ? imm_q : fwd_rs2;
    assign bus.store_data_out   = fwd_rs2;
    assign bus.alu_opcode_out   = opcode_q;
    assign bus.ex_rd_addr_out   = rd_q;
    assign bus.ex_reg_write_out = ex_reg_write;
    assign bus.ex_mem_read_out  = ex_mem_read;
    assign bus.ex_mem_write_out = valid_q & mem_write_q;

endmodule
